// File: rtl/uart_rx_oversampled.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_oversampled
// Purpose  : Oversampled UART receiver. The serial line is synchronised, a
//            falling edge starts a frame, each bit is sampled at its centre,
//            and the received word is published with a one-cycle strobe.
// Ports    : clk        - sample clock, OVERSAMPLE x baud rate
//            rst        - asynchronous active-high reset
//            in         - serial line, idle high, asynchronous to clk
//            data       - last received word (held until the next frame)
//            control    - one-cycle strobe when data/flags are updated
//            parity_err - parity mismatch on the last frame
//            frame_err  - a stop bit was sampled low on the last frame
//            busy       - receiver is inside a frame (any state but IDLE)
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_oversampled #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in,
    output logic [DATA_BITS-1:0] data,
    output logic                 control,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int c_TICK_W = $clog2(OVERSAMPLE);
    // Index also counts stop bits, so it must reach STOP_BITS (<= 2 < DATA_BITS).
    localparam int c_IDX_W  = $clog2(DATA_BITS + 1);

    localparam logic [c_TICK_W-1:0] c_TICK_MID  = c_TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(OVERSAMPLE - 1);
    localparam logic [c_IDX_W-1:0]  c_DATA_LAST = c_IDX_W'(DATA_BITS - 1);
    localparam logic [c_IDX_W-1:0]  c_STOP_DONE = c_IDX_W'(STOP_BITS);
    localparam logic                c_ODD       = (PARITY_MODE == 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [c_TICK_W-1:0]   r_tick;
    logic [c_TICK_W-1:0]   w_tick_next;
    logic [c_IDX_W-1:0]    r_idx;
    logic [c_IDX_W-1:0]    w_idx_next;

    logic                  r_sync1;
    logic                  r_rx_s;
    logic                  r_rx_prev;
    logic [DATA_BITS-1:0]  r_shift;
    logic                  r_par_bad;
    logic                  r_stop_bad;

    logic                  w_sample_data;
    logic                  w_sample_par;
    logic                  w_sample_stop;
    logic                  w_commit;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_tick  <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_tick  <= w_tick_next;
            r_idx   <= w_idx_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and sampling strobes. After START the tick counter is
    // re-aligned at mid-bit, so tick OVERSAMPLE-1 lands on the centre of
    // every following bit (data, parity and stop alike).
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        w_tick_next   = r_tick + c_TICK_W'(1);
        w_idx_next    = r_idx;
        w_sample_data = 1'b0;
        w_sample_par  = 1'b0;
        w_sample_stop = 1'b0;
        w_commit      = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_tick_next = '0;
                w_idx_next  = '0;
                if (r_rx_prev && !r_rx_s) begin
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (r_tick == c_TICK_MID) begin
                    w_tick_next  = '0;
                    // A line that is high again at mid start bit was a glitch.
                    w_state_next = r_rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_tick == c_TICK_LAST) begin
                    w_tick_next   = '0;
                    w_sample_data = 1'b1;
                    if (r_idx == c_DATA_LAST) begin
                        w_idx_next   = '0;
                        w_state_next = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                    end else begin
                        w_idx_next = r_idx + c_IDX_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (r_tick == c_TICK_LAST) begin
                    w_tick_next  = '0;
                    w_sample_par = 1'b1;
                    w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                // Once every stop bit is sampled, spend one more cycle
                // publishing the frame, then return to IDLE.
                if (r_idx == c_STOP_DONE) begin
                    w_commit     = 1'b1;
                    w_tick_next  = '0;
                    w_idx_next   = '0;
                    w_state_next = S_IDLE;
                end else if (r_tick == c_TICK_LAST) begin
                    w_tick_next   = '0;
                    w_sample_stop = 1'b1;
                    w_idx_next    = r_idx + c_IDX_W'(1);
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_tick_next  = '0;
                w_idx_next   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Synchroniser, shift buffer, error capture and output registers.
    // Synchroniser and edge register reset high so a line that is idle
    // at reset release is not mistaken for a start edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1    <= 1'b1;
            r_rx_s     <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_shift    <= '0;
            r_par_bad  <= 1'b0;
            r_stop_bad <= 1'b0;
            data       <= '0;
            control    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            r_sync1   <= in;
            r_rx_s    <= r_sync1;
            r_rx_prev <= r_rx_s;
            control   <= w_commit;

            if (r_state == S_IDLE) begin
                r_par_bad  <= 1'b0;
                r_stop_bad <= 1'b0;
            end
            if (w_sample_data) begin
                r_shift <= {r_rx_s, r_shift[DATA_BITS-1:1]};
            end
            if (w_sample_par) begin
                // Even: mismatch when data^parity is odd; odd mode inverts it.
                r_par_bad <= (^r_shift) ^ r_rx_s ^ c_ODD;
            end
            if (w_sample_stop && !r_rx_s) begin
                r_stop_bad <= 1'b1;
            end
            if (w_commit) begin
                data       <= r_shift;
                parity_err <= r_par_bad;
                frame_err  <= r_stop_bad;
            end
        end
    end

    assign busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/uart_rx_oversampled.md
UART_RX_OVERSAMPLED -- requirements
Module: uart_rx_oversampled

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-002 SHALL have parameter OVERSAMPLE, default 16, clk cycles per bit; even; legal range 4..64.
REQ-003 SHALL have parameter PARITY_MODE, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-004 SHALL have parameter STOP_BITS, default 1, number of stop bits; legal values 1 or 2.
REQ-005 SHALL have port clk, input, 1, single clock at OVERSAMPLE x baud rate.
REQ-006 SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-007 SHALL have port in, input, 1, serial line from Raspberry Pi; idle high; asynchronous to clk.
REQ-008 SHALL have port data, output, DATA_BITS, last received word.
REQ-009 SHALL have port control, output, 1, one-cycle valid/enable pulse to the decoder.
REQ-010 SHALL have port parity_err, output, 1, parity mismatch on the last frame.
REQ-011 SHALL have port frame_err, output, 1, low stop bit on the last frame.
REQ-012 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-013 SHALL pass in through a 2-flop synchronizer; all logic uses the synchronized bit (rx_s).
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP, plus a tick counter 0..OVERSAMPLE-1 and a bit index 0..DATA_BITS-1.
REQ-015 IDLE: on a falling edge of rx_s (previous 1, current 0), SHALL go to START with the tick counter at 0.
REQ-016 START: at tick OVERSAMPLE/2-1 (mid-bit), if rx_s=1 SHALL treat it as a glitch and go to IDLE with no output change; else SHALL clear the tick counter and go to DATA.
REQ-017 DATA: SHALL sample rx_s at tick OVERSAMPLE-1, placing samples LSB first into a shift buffer; after DATA_BITS samples SHALL go to PARITY if PARITY_MODE!=0, else to STOP.
REQ-018 PARITY: SHALL sample one bit at mid-bit; mismatch SHALL be XOR(data bits)^sample != 0 for even and ==0 for odd.
REQ-019 STOP: SHALL sample STOP_BITS bits at mid-bit; any sampled 0 SHALL set the frame error for that frame.
REQ-020 After the last stop sample, on the next clk edge: data <= buffer, parity_err and frame_err updated, control=1 for exactly one cycle, state to IDLE.
REQ-021 data, parity_err and frame_err SHALL hold until the next completed frame; a frame with an error SHALL still update data and pulse control.
REQ-022 data, parity_err and frame_err SHALL never change outside the REQ-020 update cycle.
REQ-023 Line held low (break) SHALL produce one frame with frame_err=1, then no further frame until rx_s returns high and falls again.
REQ-024 Back-to-back frames SHALL be received when the next start edge occurs in the first IDLE cycle after the stop bit.
REQ-025 Latency SHALL be: control asserted 2 (sync) + 1 + OVERSAMPLE/2 + (DATA_BITS+P+STOP_BITS)*OVERSAMPLE cycles after the in falling edge, within ±1 cycle, where P=1 if parity is enabled.
REQ-026 When DATA_BITS<9, unused buffer bits SHALL NOT exist.

Reset
REQ-027 While rst=1: state IDLE, counters 0, synchronizer flops and edge register 1, data=0, control=0, parity_err=0, frame_err=0, busy=0.
REQ-028 rst asserted mid-frame SHALL abort the frame with no control pulse; reception SHALL resume on the first falling edge after rst is released.

Verification (defaults DATA_BITS=8, OVERSAMPLE=16 unless stated)
REQ-029 PARITY_MODE=0: send 0xA5 at 16 clk/bit -> data=0xA5, one-cycle control pulse, both error flags 0, busy low afterwards.
REQ-030 Glitch: in low for 4 clk, then high -> no control pulse, busy returns to 0, data unchanged.
REQ-031 PARITY_MODE=1: send 0x03 with parity bit 1 -> data=0x03, parity_err=1; then send 0x03 with parity bit 0 -> parity_err=0.
REQ-032 Stop bit driven 0 on 0x3C -> data=0x3C, frame_err=1; then a clean 0x3C clears frame_err.
REQ-033 rst pulsed during data bit 3, then full frame 0x5A sent -> exactly one control pulse, data=0x5A.
REQ-034 STOP_BITS=1: frames 0x00 and 0xFF sent back-to-back -> two control pulses, with data 0x00 then 0xFF.
